// File: rtl/cvxif_mux_pkg.sv
// Shared types and the vector-opcode routing helper for the CV-X-IF coprocessor mux.
package cvxif_mux_pkg;
  localparam int NUM_VEC_OPC = 3;
  localparam logic [NUM_VEC_OPC-1:0][6:0] vec_opcodes = {7'h57, 7'h07, 7'h27};

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_e;
  typedef logic cop_sel_t;

  // 0 = vector unit, 1 = scalar custom unit
  function automatic cop_sel_t route_dst(input logic [6:0] opc,
                                         input logic [NUM_VEC_OPC-1:0][6:0] tbl);
    route_dst = 1'b1;
    for (int i = 0; i < NUM_VEC_OPC; i++)
      if (opc == tbl[i]) route_dst = 1'b0;
  endfunction
endpackage

// File: rtl/cvxif_pkg.sv
// Minimal CV-X-IF request/response types as seen at the CVA6 coprocessor port.
package cvxif_pkg;
  localparam int TRANS_ID_BITS = 3;
  localparam int X_NUM_RS      = 2;
  localparam int XLEN          = 32;

  typedef struct packed {
    logic [31:0]                   instr;
    logic [1:0]                    mode;
    logic [TRANS_ID_BITS-1:0]      id;
    logic [X_NUM_RS-1:0][XLEN-1:0] rs;
    logic [X_NUM_RS-1:0]           rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic                     x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [31:0]              addr;
    logic [1:0]               mode;
    logic                     we;
    logic [1:0]               size;
    logic [XLEN-1:0]          wdata;
    logic                     last;
    logic                     spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } x_mem_resp_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          rdata;
    logic                     err;
  } x_mem_result_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          data;
    logic [4:0]               rd;
    logic                     we;
    logic                     exc;
    logic [5:0]               exccode;
  } x_result_t;

  typedef struct packed {
    logic          x_issue_valid;
    x_issue_req_t  x_issue_req;
    logic          x_commit_valid;
    x_commit_t     x_commit;
    logic          x_mem_ready;
    logic          x_mem_resp_valid;
    x_mem_resp_t   x_mem_resp;
    logic          x_mem_result_valid;
    x_mem_result_t x_mem_result;
    logic          x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_mem_valid;
    x_mem_req_t    x_mem_req;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;
endpackage

// File: rtl/cvxif_result_arb.sv
// Result-channel arbiter: picks a coprocessor in IDLE and locks it while the CPU stalls.
// CVXIF_MUX_RR_EN selects round-robin in IDLE; otherwise port 0 has fixed priority.
module cvxif_result_arb
  import cvxif_mux_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       ready_i,
  output cop_sel_t   gnt_o,
  output logic       hs_o
);
  arb_state_e state_q, state_d;
  cop_sel_t   pick;

`ifdef CVXIF_MUX_RR_EN
  cop_sel_t rr_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni)   rr_ptr_q <= 1'b0;
    else if (hs_o) rr_ptr_q <= ~gnt_o;

  always_comb begin
    pick = valid_i[0] ? 1'b0 : 1'b1;
    if (&valid_i) pick = rr_ptr_q;
  end
`else
  assign pick = valid_i[0] ? 1'b0 : 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (valid_i[pick] && !ready_i) state_d = pick ? LOCK1 : LOCK0;
      LOCK0, LOCK1: if (hs_o) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // A locked grant keeps the payload stable until the CPU takes it
  always_comb begin
    gnt_o = pick;
    case (state_q)
      LOCK0:   gnt_o = 1'b0;
      LOCK1:   gnt_o = 1'b1;
      default: gnt_o = pick;
    endcase
  end

  assign hs_o = valid_i[gnt_o] & ready_i;
endmodule

// File: rtl/cvxif_coproc_mux.sv
// Shares the CVA6 CV-X-IF port between the vector unit (port 0) and a scalar unit (port 1).
// Result arbitration policy is set by CVXIF_MUX_RR_EN (see cvxif_result_arb).
module cvxif_coproc_mux
  import cvxif_pkg::*;
  import cvxif_mux_pkg::*;
#(
  parameter int unsigned                    X_ID_WIDTH  = cvxif_pkg::TRANS_ID_BITS,
  parameter logic [NUM_VEC_OPC-1:0][6:0]    VEC_OPCODES = vec_opcodes
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  cvxif_req_t                  cpu_req_i,
  output cvxif_resp_t                 cpu_resp_o,
  output cvxif_req_t  [1:0]           cop_req_o,
  input  cvxif_resp_t [1:0]           cop_resp_i,
  output logic        [1:0][X_ID_WIDTH:0] inflight_o
);
  localparam int NUM_IDS = 1 << X_ID_WIDTH;
  localparam int CW      = X_ID_WIDTH + 1;

  logic [NUM_IDS-1:0]    tbl_valid_q, tbl_valid_d;
  logic [NUM_IDS-1:0]    tbl_owner_q, tbl_owner_d;
  logic [X_ID_WIDTH-1:0] iss_id, cmt_id, res_id;
  cop_sel_t              dst, gnt;
  logic                  stall, iss_fwd, iss_hs, iss_set;
  logic                  cmt_ok, kill_clr, res_hs, res_clr, res_only;
  logic [1:0]            res_valid;
  logic                  unused_mem1;

  assign iss_id = cpu_req_i.x_issue_req.id;
  assign cmt_id = cpu_req_i.x_commit.id;
  assign res_id = cop_resp_i[gnt].x_result.id;

  assign dst      = route_dst(cpu_req_i.x_issue_req.instr[6:0], VEC_OPCODES);
  assign stall    = tbl_valid_q[iss_id];
  assign iss_fwd  = cpu_req_i.x_issue_valid & ~stall;
  assign iss_hs   = iss_fwd & cop_resp_i[dst].x_issue_ready;
  assign iss_set  = iss_hs & cop_resp_i[dst].x_issue_resp.accept;
  assign cmt_ok   = cpu_req_i.x_commit_valid & tbl_valid_q[cmt_id];
  assign kill_clr = cmt_ok & cpu_req_i.x_commit.x_commit_kill;
  assign res_clr  = res_hs & tbl_valid_q[res_id];
  // Kill and result on one ID retire a single entry
  assign res_only = res_clr & ~(kill_clr & (cmt_id == res_id));

  assign res_valid   = {cop_resp_i[1].x_result_valid, cop_resp_i[0].x_result_valid};
  assign unused_mem1 = ^{cop_resp_i[1].x_mem_valid, cop_resp_i[1].x_mem_req};

  cvxif_result_arb u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (res_valid),
    .ready_i (cpu_req_i.x_result_ready),
    .gnt_o   (gnt),
    .hs_o    (res_hs)
  );

  // An issue never targets a valid entry, so set and clear cannot collide
  always_comb begin
    tbl_valid_d = tbl_valid_q;
    tbl_owner_d = tbl_owner_q;
    if (kill_clr) tbl_valid_d[cmt_id] = 1'b0;
    if (res_clr)  tbl_valid_d[res_id] = 1'b0;
    if (iss_set) begin
      tbl_valid_d[iss_id] = 1'b1;
      tbl_owner_d[iss_id] = dst;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tbl_valid_q <= '0;
      tbl_owner_q <= '0;
    end else begin
      tbl_valid_q <= tbl_valid_d;
      tbl_owner_q <= tbl_owner_d;
    end

  for (genvar n = 0; n < 2; n++) begin : g_cnt
    logic          inc, dec_k, dec_r;
    logic [CW-1:0] cnt_q, cnt_d;
    assign inc   = iss_set & (dst == cop_sel_t'(n));
    assign dec_k = kill_clr & (tbl_owner_q[cmt_id] == cop_sel_t'(n));
    assign dec_r = res_only & (tbl_owner_q[res_id] == cop_sel_t'(n));
    assign cnt_d = cnt_q + CW'(inc) - CW'(dec_k) - CW'(dec_r);
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    assign inflight_o[n] = cnt_q;
  end

  // Outputs are forced to zero while reset is asserted
  always_comb begin
    cpu_resp_o = '0;
    cop_req_o  = '0;
    if (rst_ni) begin
      for (int n = 0; n < 2; n++) begin
        cop_req_o[n].x_issue_req    = cpu_req_i.x_issue_req;
        cop_req_o[n].x_issue_valid  = iss_fwd & (dst == cop_sel_t'(n));
        cop_req_o[n].x_commit       = cpu_req_i.x_commit;
        cop_req_o[n].x_commit_valid = cmt_ok & (tbl_owner_q[cmt_id] == cop_sel_t'(n));
        cop_req_o[n].x_result_ready = cpu_req_i.x_result_ready & (gnt == cop_sel_t'(n));
      end
      cop_req_o[0].x_mem_ready        = cpu_req_i.x_mem_ready;
      cop_req_o[0].x_mem_resp_valid   = cpu_req_i.x_mem_resp_valid;
      cop_req_o[0].x_mem_resp         = cpu_req_i.x_mem_resp;
      cop_req_o[0].x_mem_result_valid = cpu_req_i.x_mem_result_valid;
      cop_req_o[0].x_mem_result       = cpu_req_i.x_mem_result;

      cpu_resp_o.x_issue_ready  = cop_resp_i[dst].x_issue_ready & ~stall;
      cpu_resp_o.x_issue_resp   = cop_resp_i[dst].x_issue_resp;
      cpu_resp_o.x_mem_valid    = cop_resp_i[0].x_mem_valid;
      cpu_resp_o.x_mem_req      = cop_resp_i[0].x_mem_req;
      cpu_resp_o.x_result_valid = cop_resp_i[gnt].x_result_valid;
      cpu_resp_o.x_result       = cop_resp_i[gnt].x_result;
    end
  end

  // The scalar unit has no memory path
  a_no_ls_port1: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(iss_hs && dst && cop_resp_i[1].x_issue_resp.accept && cop_resp_i[1].x_issue_resp.loadstore));
endmodule

// File: tb/tb_cvxif_coproc_mux.sv
// Directed bench for cvxif_coproc_mux with an ownership/arbitration model checked every cycle.
module tb_cvxif_coproc_mux;
  import cvxif_pkg::*;
  import cvxif_mux_pkg::*;

  localparam int IDW = TRANS_ID_BITS;
  localparam int NID = 1 << IDW;
`ifdef CVXIF_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cvxif_req_t        cpu_req = '0;
  cvxif_resp_t       cpu_resp;
  cvxif_req_t  [1:0] cop_req;
  cvxif_resp_t [1:0] cop_resp = '0;
  logic [1:0][IDW:0] inflight;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cvxif_coproc_mux dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cpu_req_i  (cpu_req),
    .cpu_resp_o (cpu_resp),
    .cop_req_o  (cop_req),
    .cop_resp_i (cop_resp),
    .inflight_o (inflight)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: who owns which ID, what is held, whose turn ----------------
  bit m_valid [NID];
  bit m_owner [NID];
  bit m_clr   [NID];
  int m_cnt   [2];
  int m_lock = -1;
  bit m_rr;
  int md, mg, miid, mcid, mrid;
  bit mstl, many;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_cpu_resp_zero", cpu_resp == '0, 1);
      chk("rst_cop_req_zero", cop_req == '0, 1);
      chk("rst_inflight", inflight, 0);
      for (int i = 0; i < NID; i++) m_valid[i] = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_lock = -1; m_rr = 0;
    end else begin
      md   = (cpu_req.x_issue_req.instr[6:0] inside {7'h57, 7'h07, 7'h27}) ? 0 : 1;
      miid = int'(cpu_req.x_issue_req.id);
      mcid = int'(cpu_req.x_commit.id);
      mstl = m_valid[miid];
      for (int n = 0; n < 2; n++) begin
        chk("m_issue_valid", cop_req[n].x_issue_valid, cpu_req.x_issue_valid && !mstl && md == n);
        chk("m_commit_valid", cop_req[n].x_commit_valid,
            cpu_req.x_commit_valid && m_valid[mcid] && int'(m_owner[mcid]) == n);
        chk("m_inflight", inflight[n], m_cnt[n]);
      end
      chk("m_issue_ready", cpu_resp.x_issue_ready, cop_resp[md].x_issue_ready && !mstl);
      chk("m_issue_resp", cpu_resp.x_issue_resp, cop_resp[md].x_issue_resp);
      chk("m_mem_ready0", cop_req[0].x_mem_ready, cpu_req.x_mem_ready);
      chk("m_mem_ready1", cop_req[1].x_mem_ready, 0);
      chk("m_mem_valid", cpu_resp.x_mem_valid, cop_resp[0].x_mem_valid);

      many = cop_resp[0].x_result_valid || cop_resp[1].x_result_valid;
      if (m_lock >= 0)                                            mg = m_lock;
      else if (cop_resp[0].x_result_valid && cop_resp[1].x_result_valid) mg = RR ? int'(m_rr) : 0;
      else                                                        mg = cop_resp[0].x_result_valid ? 0 : 1;
      chk("m_res_valid", cpu_resp.x_result_valid, many ? cop_resp[mg].x_result_valid : 1'b0);
      if (many) begin
        chk("m_res_data", cpu_resp.x_result.data, cop_resp[mg].x_result.data);
        chk("m_res_ready_gnt", cop_req[mg].x_result_ready, cpu_req.x_result_ready);
        chk("m_res_ready_other", cop_req[1-mg].x_result_ready, 0);
      end

      // next state of the model
      for (int i = 0; i < NID; i++) m_clr[i] = 0;
      if (cpu_req.x_commit_valid && cpu_req.x_commit.x_commit_kill && m_valid[mcid]) m_clr[mcid] = 1;
      if (many && cop_resp[mg].x_result_valid && cpu_req.x_result_ready) begin
        mrid = int'(cop_resp[mg].x_result.id);
        if (m_valid[mrid]) m_clr[mrid] = 1;
        m_lock = -1;
        m_rr = (mg == 0);
      end else if (many && cop_resp[mg].x_result_valid) begin
        m_lock = mg;
      end
      for (int i = 0; i < NID; i++)
        if (m_clr[i]) begin m_valid[i] = 0; m_cnt[m_owner[i]]--; end
      if (cpu_req.x_issue_valid && !mstl && cop_resp[md].x_issue_ready && cop_resp[md].x_issue_resp.accept) begin
        m_valid[miid] = 1; m_owner[miid] = md[0]; m_cnt[md]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] instr, input int id);
    cpu_req.x_issue_valid = 1'b1;
    cpu_req.x_issue_req.instr = instr;
    cpu_req.x_issue_req.id = IDW'(id);
  endtask

  task automatic result(input int port, input int id, input logic [31:0] data);
    cop_resp[port].x_result_valid = 1'b1;
    cop_resp[port].x_result.id = IDW'(id);
    cop_resp[port].x_result.data = data;
  endtask

  logic [3:0] exp_rr, exp_fx;

  initial begin
    exp_rr = 4'b1010;  // grant sequence, bit k = port in cycle k
    exp_fx = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2 chk("inflight_after_reset", inflight, 0);

    // OP-V id3 -> port 0, custom id4 -> port 1, custom id2 rejected
    cyc(); issue(32'h0000_0057, 3);
    cop_resp[0].x_issue_ready = 1; cop_resp[0].x_issue_resp.accept = 1;
    #2 chk("t1_fwd0", cop_req[0].x_issue_valid, 1); chk("t1_fwd1", cop_req[1].x_issue_valid, 0);
    chk("t1_rdy", cpu_resp.x_issue_ready, 1);
    cyc(); cop_resp[0] = '0; issue(32'h0000_000B, 4);
    cop_resp[1].x_issue_ready = 1; cop_resp[1].x_issue_resp.accept = 1;
    #2 chk("t1_fwd1b", cop_req[1].x_issue_valid, 1);
    cyc(); issue(32'h0000_000B, 2); cop_resp[1].x_issue_resp.accept = 0;
    cyc();
    #2 chk("t1_inflight0", inflight[0], 1); chk("t1_inflight1", inflight[1], 1);
    chk("t1_rejected_not_stalled", cpu_resp.x_issue_ready, 1);
    cyc(); cpu_req.x_issue_valid = 0; cop_resp[1] = '0;

    // commits steered by owner; result frees id4
    cpu_req.x_commit_valid = 1; cpu_req.x_commit.id = 4;
    #2 chk("t2_cmt4_p1", cop_req[1].x_commit_valid, 1); chk("t2_cmt4_p0", cop_req[0].x_commit_valid, 0);
    cyc(); cpu_req.x_commit.id = 3;
    #2 chk("t2_cmt3_p0", cop_req[0].x_commit_valid, 1); chk("t2_cmt3_p1", cop_req[1].x_commit_valid, 0);
    cyc(); cpu_req.x_commit_valid = 0; result(1, 4, 32'h44); cpu_req.x_result_ready = 1;
    #2 chk("t2_res_data", cpu_resp.x_result.data, 32'h44); chk("t2_res_rdy1", cop_req[1].x_result_ready, 1);
    cyc(); cop_resp[1] = '0; cpu_req.x_commit_valid = 1; cpu_req.x_commit.id = 4;
    #2 chk("t2_inflight1", inflight[1], 0); chk("t2_inflight0", inflight[0], 1);
    chk("t2_cmt_dropped", cop_req[1].x_commit_valid, 0);

    // both results valid continuously, ready=1
    cyc(); cpu_req.x_commit_valid = 0; cpu_req.x_mem_ready = 1; cop_resp[0].x_mem_valid = 1;
    result(0, 0, 32'hA0); result(1, 1, 32'hB1);
    for (int k = 0; k < 4; k++) begin
      #2 chk("t3_grant", cpu_resp.x_result.data == 32'hB1, RR ? exp_rr[k] : exp_fx[k]);
      cyc();
    end
    cop_resp[0].x_result_valid = 0;
    #2 chk("t3_after_drop", cpu_resp.x_result.data, 32'hB1);
    cyc(); cop_resp = '0; cpu_req.x_mem_ready = 0; cpu_req.x_result_ready = 0;

    // port 1 held by a stalled CPU, port 0 arrives late
    result(1, 1, 32'hB2);
    for (int k = 0; k < 3; k++) begin
      #2 chk("t4_hold", cpu_resp.x_result.data, 32'hB2);
      cyc();
    end
    result(0, 0, 32'hA2);
    #2 chk("t4_locked", cpu_resp.x_result.data, 32'hB2); chk("t4_no_rdy0", cop_req[0].x_result_ready, 0);
    cyc(); cpu_req.x_result_ready = 1;
    #2 chk("t4_hs_p1", cop_req[1].x_result_ready, 1); chk("t4_data", cpu_resp.x_result.data, 32'hB2);
    cyc(); cop_resp[1].x_result_valid = 0;
    #2 chk("t4_then_p0", cpu_resp.x_result.data, 32'hA2);
    cyc(); cop_resp = '0; cpu_req.x_result_ready = 0;

    // re-issue id3 while in flight; kill+result on id3 together
    issue(32'h0000_0057, 3); cop_resp[0].x_issue_ready = 1; cop_resp[0].x_issue_resp.accept = 1;
    #2 chk("t5_stall_rdy", cpu_resp.x_issue_ready, 0); chk("t5_stall_fwd", cop_req[0].x_issue_valid, 0);
    cyc(); cpu_req.x_commit_valid = 1; cpu_req.x_commit.id = 3; cpu_req.x_commit.x_commit_kill = 1;
    result(0, 3, 32'h33); cpu_req.x_result_ready = 1;
    #2 chk("t5_no_bypass", cpu_resp.x_issue_ready, 0);
    cyc(); cpu_req.x_commit = '0; cpu_req.x_commit_valid = 0; cop_resp[0].x_result_valid = 0;
    cpu_req.x_result_ready = 0;
    #2 chk("t5_proceed", cop_req[0].x_issue_valid, 1); chk("t5_cleared_once", inflight[0], 0);
    cyc(); cpu_req.x_issue_valid = 0; cop_resp = '0;
    #2 chk("t5_reissued", inflight[0], 1);

    // id5 on port 0, id6 on port 1, then reset in the middle of a kill
    cyc(); issue(32'h0000_0057, 5); cop_resp[0].x_issue_ready = 1; cop_resp[0].x_issue_resp.accept = 1;
    cyc(); cop_resp[0] = '0; issue(32'h0000_000B, 6);
    cop_resp[1].x_issue_ready = 1; cop_resp[1].x_issue_resp.accept = 1;
    cyc(); cpu_req.x_issue_valid = 0; cop_resp = '0;
    cpu_req.x_commit_valid = 1; cpu_req.x_commit.id = 5; cpu_req.x_commit.x_commit_kill = 1;
    result(1, 6, 32'h66);
    #1 chk("t6_pre_inflight1", inflight[1], 1);
    rst_n = 1'b0;
    #1 chk("t6_cop_req_low", cop_req == '0, 1); chk("t6_cpu_resp_low", cpu_resp == '0, 1);
    chk("t6_inflight", inflight, 0);
    cyc(); rst_n = 1'b1; cpu_req = '0; cop_resp = '0;
    issue(32'h0000_0057, 5); cop_resp[0].x_issue_ready = 1;
    #2 chk("t6_id5_free", cpu_resp.x_issue_ready, 1); chk("t6_inflight_post", inflight, 0);
    cyc(); cpu_req = '0; cop_resp = '0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
